// File: rtl/uart_rx_frame.sv
// uart_rx_frame: asynchronous serial receiver feeding the LED control stage.
// Receives 8N1 frames by default. Define UART_RX_PARITY_EN to receive 8E1
// frames, which adds a PARITY state and a parity check.
//
// Ports:
//   sys_clk    - system clock
//   sys_rst    - synchronous active-high reset
//   uart_rxd   - asynchronous serial input, idle high
//   uart_data  - last correctly received byte, held until the next good frame
//   uart_done  - one-cycle pulse, uart_data has just been updated
//   frame_err  - one-cycle pulse, stop bit sampled low
//   parity_err - one-cycle pulse, parity mismatch (tied 0 without the macro)
//   busy       - high while a frame is being received
module uart_rx_frame #(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned UART_BPS = 115200
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       uart_rxd,
  output logic [7:0] uart_data,
  output logic       uart_done,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  localparam int unsigned BPS_CNT = CLK_FREQ / UART_BPS;
  localparam int unsigned CNT_W   = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(BPS_CNT / 2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BPS_CNT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    S_PARITY = 3'd4,
`endif
    S_STOP   = 3'd3
  } state_t;

  // Three-flop synchronizer; all stages reset to the idle (high) level.
  logic rxd_d0_q, rxd_d1_q, rxd_d2_q;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       uart_data_q, uart_data_d;
  logic             uart_done_q, uart_done_d;
  logic             frame_err_q, frame_err_d;
  logic             busy_q, busy_d;

  logic start_flag;
  logic mid_bit;
  logic bit_end;

`ifdef UART_RX_PARITY_EN
  logic par_bit_q, par_bit_d;
  logic parity_err_q, parity_err_d;
  logic par_bad;
`endif

  // Falling edge on the synchronised line.
  assign start_flag = rxd_d2_q & ~rxd_d1_q;
  assign mid_bit    = (clk_cnt_q == CNT_MID);
  assign bit_end    = (clk_cnt_q == CNT_LAST);

`ifdef UART_RX_PARITY_EN
  // Even parity: the parity bit must equal the XOR of the data bits.
  assign par_bad = (par_bit_q != ^shift_q);
`endif

  // Next-state and output decode.
  always_comb begin
    state_d     = state_q;
    clk_cnt_d   = clk_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    uart_data_d = uart_data_q;
    uart_done_d = 1'b0;
    frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bit_d    = par_bit_q;
    parity_err_d = 1'b0;
`endif

    if (state_q != S_IDLE) begin
      clk_cnt_d = bit_end ? '0 : clk_cnt_q + CNT_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        clk_cnt_d = '0;
        bit_cnt_d = '0;
        if (start_flag) begin
          state_d = S_START;
        end
      end

      S_START: begin
        // A start bit that is high again at mid-bit was only a glitch.
        if (mid_bit && rxd_d1_q) begin
          state_d = S_IDLE;
        end else if (bit_end) begin
          state_d   = S_DATA;
          bit_cnt_d = '0;
        end
      end

      S_DATA: begin
        if (mid_bit) begin
          shift_d = {rxd_d1_q, shift_q[7:1]};
        end
        if (bit_end) begin
          if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (mid_bit) begin
          par_bit_d = rxd_d1_q;
        end
        if (bit_end) begin
          state_d = S_STOP;
        end
      end
`endif

      S_STOP: begin
        // Decide at mid stop bit so a slightly fast sender can start the
        // next frame immediately; frame error outranks parity error.
        if (mid_bit) begin
          state_d = S_IDLE;
          if (!rxd_d1_q) begin
            frame_err_d = 1'b1;
`ifdef UART_RX_PARITY_EN
          end else if (par_bad) begin
            parity_err_d = 1'b1;
`endif
          end else begin
            uart_data_d = shift_q;
            uart_done_d = 1'b1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rxd_d0_q    <= 1'b1;
      rxd_d1_q    <= 1'b1;
      rxd_d2_q    <= 1'b1;
      state_q     <= S_IDLE;
      clk_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      uart_data_q <= '0;
      uart_done_q <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      rxd_d0_q    <= uart_rxd;
      rxd_d1_q    <= rxd_d0_q;
      rxd_d2_q    <= rxd_d1_q;
      state_q     <= state_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      uart_data_q <= uart_data_d;
      uart_done_q <= uart_done_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
`ifdef UART_RX_PARITY_EN
      par_bit_q    <= par_bit_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign uart_data = uart_data_q;
  assign uart_done = uart_done_q;
  assign frame_err = frame_err_q;
  assign busy      = busy_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: doc/uart_rx_frame.md
Name: uart_rx_frame

Overview:
UART receiver that deserialises an asynchronous 8N1 serial line (RS485 transceiver RO output) into bytes. It sits directly upstream of the LED control stage. Each valid byte is delivered on uart_data with a one-cycle uart_done pulse; the LED stage uses the rising edge of that pulse as its enable and the low nibble as its data. Framing faults are flagged, and faulty bytes are never delivered.

Parameters:
CLK_FREQ, 50_000_000, system clock frequency in Hz
UART_BPS, 115200, line baud rate
BPS_CNT (localparam), CLK_FREQ/UART_BPS (434 at defaults), clocks per bit

Ports:
sys_clk    input   1  system clock, 50 MHz
sys_rst    input   1  reset; synchronous, active-high
uart_rxd   input   1  asynchronous serial input; idle high
uart_data  output  8  last correctly received byte
uart_done  output  1  one-cycle pulse: uart_data has just been updated
frame_err  output  1  one-cycle pulse: stop bit sampled low
parity_err output  1  one-cycle pulse: parity mismatch (constant 0 without the macro)
busy       output  1  high while a frame is being received (state != IDLE)

Behaviour:
- Interface: one clock, sys_clk. Reset sys_rst is synchronous and active-high; every register changes only on the sys_clk rising edge.
- Reset values: uart_data=8'h00, uart_done=0, frame_err=0, parity_err=0, busy=0, state=IDLE. The synchronizer regs reset to 1 (idle line).
- Sync: 3-flop chain rxd_d0 -> rxd_d1 -> rxd_d2. start_flag = rxd_d2 & ~rxd_d1, i.e. a falling edge on the synchronised line.
- Bit timing:
  - clk_cnt counts 0..BPS_CNT-1, then wraps to 0 and bit_cnt increments.
  - The line (rxd_d1) is sampled when clk_cnt == BPS_CNT/2 (mid-bit).
  - clk_cnt is cleared on entry to START.
- FSM:
  - IDLE: on start_flag -> START.
  - START: at the mid-bit sample, rxd_d1==1 is a glitch -> IDLE with no flags. rxd_d1==0 continues; at the clk_cnt wrap -> DATA.
  - DATA: 8 bits, LSB first, shifted into a shift register at mid-bit. After bit 7 wraps -> PARITY (macro) or STOP.
  - PARITY: macro builds only; see Optional Feature.
  - STOP: at mid-bit, go to IDLE immediately, without waiting for the full stop bit. This gives tolerance to a fast transmitter and allows back-to-back frames.
    - Stop sampled 1 and no parity error: uart_data <= shift reg; uart_done=1 for one cycle.
    - Stop sampled 0: frame_err=1 for one cycle; uart_data holds.
- Latency: uart_done rises on the clock after the stop-bit mid-sample. uart_data is valid in the same cycle uart_done is high and holds until the next good frame.
- A falling edge while busy is ignored; no restart mid-frame.
- Line stuck low after a frame error: no new start_flag until the line returns high and falls again.
- Reset mid-frame: next cycle is IDLE, outputs at reset values, partial byte discarded.
- Flags are mutually exclusive per frame. If both stop and parity are bad, frame_err takes priority.

Optional Feature:
UART_RX_PARITY_EN
- Defined: frame is 8E1. A PARITY state follows DATA. The mid-bit sample is compared with the XOR of the 8 data bits (even parity).
  - Mismatch: parity_err pulses one cycle at the stop-bit decision; uart_done is suppressed; uart_data holds.
  - Stop-bit handling is unchanged.
- Undefined: 8N1; the PARITY state is not built; parity_err is tied 0.

Test Plan:
- Send 0x55 at 115200 (8680 ns/bit) -> exactly one uart_done pulse, uart_data=0x55, frame_err=0, busy high for about 9.5 bit times.
- Back-to-back 0xA3 then 0x0F, no idle gap -> two uart_done pulses about 10 bit times apart; data 0xA3 then 0x0F.
- Low glitch on uart_rxd for 100 clocks -> no uart_done or frame_err; busy drops after about 0.5 bit; a following 0x12 is received correctly.
- Send 0x3C with stop bit driven 0 (prior byte 0x55) -> frame_err one-cycle pulse, no uart_done, uart_data stays 0x55.
- Assert sys_rst for one cycle during data bit 4 of 0xF0 -> next cycle uart_data=0x00 and busy=0; a subsequent 0x81 is received correctly.
- With UART_RX_PARITY_EN: 0x07 with parity bit 0 (should be 1) -> parity_err pulse, no uart_done. 0x07 with parity 1 -> uart_done with 0x07.
